// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM demultiplexer.
// Optional parity checking in tdm_demux is enabled by defining TDM_DEMUX_PARITY_EN.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned DEF_DW  = 8;
  localparam int unsigned DEF_NCH = 4;

  // Bit offset of channel k inside a flattened frame of dw-bit samples.
  function automatic int unsigned chan_off(input int unsigned k, input int unsigned dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demultiplexer: clear, load-1 and increment,
// with a flag marking the last slot of a frame.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int unsigned NCH = DEF_NCH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     ld1_i,
  input  logic                     inc_i,
  output logic [$clog2(NCH)-1:0]   slot_o,
  output logic                     last_o
);

  localparam int unsigned SW = $clog2(NCH);

  logic [SW-1:0] slot_q;

  // Slot register; clear wins over load-1, which wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else if (clr_i) begin
      slot_q <= '0;
    end else if (ld1_i) begin
      slot_q <= SW'(1);
    end else if (inc_i) begin
      slot_q <= slot_q + SW'(1);
    end
  end

  assign slot_o = slot_q;
  assign last_o = (slot_q == SW'(NCH - 1));

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: collects NCH consecutive samples of one TDM
// lane, aligned by a slot-0 sync marker, and publishes them as one frame.
// Define TDM_DEMUX_PARITY_EN to add din_par / par_err even-parity checking.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned DW  = DEF_DW,
  parameter int unsigned NCH = DEF_NCH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     din,
  input  logic              din_valid,
  input  logic              sync,
  output logic [NCH*DW-1:0] dout,
  output logic              frame_valid,
  output logic              sync_err,
  output logic              locked
`ifdef TDM_DEMUX_PARITY_EN
  ,
  input  logic              din_par,
  output logic              par_err
`endif
);

  localparam int unsigned SW = $clog2(NCH);

  state_e              state_q, state_d;
  logic [DW-1:0]       shadow_q [NCH];
  logic [DW-1:0]       shadow_d [NCH];
  logic [DW-1:0]       frame_c  [NCH];
  logic [NCH*DW-1:0]   dout_q, dout_d;
  logic                fv_q, fv_d;
  logic                se_q, se_d;
  logic                locked_q, locked_d;

  logic [SW-1:0]       slot_q;
  logic                last_c;
  logic                ctr_clr, ctr_ld1, ctr_inc;
  logic                frame_bad_c;

  tdm_slot_ctr #(
    .NCH (NCH)
  ) u_slot_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (ctr_clr),
    .ld1_i  (ctr_ld1),
    .inc_i  (ctr_inc),
    .slot_o (slot_q),
    .last_o (last_c)
  );

`ifdef TDM_DEMUX_PARITY_EN
  logic par_bad_c;
  logic bad_q, bad_d;
  logic perr_q, perr_d;

  assign par_bad_c   = ^{din, din_par};
  assign frame_bad_c = bad_q | par_bad_c;

  // Tracks whether the frame being collected has seen a parity error.
  always_comb begin
    bad_d  = bad_q;
    perr_d = 1'b0;
    if (din_valid) begin
      if (sync) begin
        bad_d = par_bad_c;
      end else if (state_q == RUN) begin
        if (slot_q == '0) begin
          bad_d = 1'b0;
        end else begin
          bad_d  = bad_q | par_bad_c;
          perr_d = last_c & (bad_q | par_bad_c);
        end
      end
    end
  end

  // Parity bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      bad_q  <= bad_d;
      perr_q <= perr_d;
    end
  end

  assign par_err = perr_q;
`else
  assign frame_bad_c = 1'b0;
`endif

  // Framing FSM: next state, shadow writes, counter control and output loads.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    fv_d     = 1'b0;
    se_d     = 1'b0;
    ctr_clr  = 1'b0;
    ctr_ld1  = 1'b0;
    ctr_inc  = 1'b0;
    frame_c  = shadow_q;
    frame_c[NCH-1] = din;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_d[0] = din;
            ctr_ld1     = 1'b1;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (sync) begin
            // A sync anywhere but slot 0 drops the partial frame.
            se_d        = (slot_q != '0);
            shadow_d[0] = din;
            ctr_ld1     = 1'b1;
          end else if (slot_q == '0) begin
            se_d    = 1'b1;
            ctr_clr = 1'b1;
            state_d = HUNT;
          end else if (last_c) begin
            ctr_clr = 1'b1;
            if (!frame_bad_c) begin
              fv_d = 1'b1;
              for (int unsigned k = 0; k < NCH; k++) begin
                dout_d[chan_off(k, DW) +: DW] = frame_c[k];
              end
            end
          end else begin
            shadow_d[slot_q] = din;
            ctr_inc          = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == RUN);
  end

  // State, shadow and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      shadow_q <= '{default: '0};
      dout_q   <= '0;
      fv_q     <= 1'b0;
      se_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      fv_q     <= fv_d;
      se_q     <= se_d;
      locked_q <= locked_d;
    end
  end

  assign dout        = dout_q;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed scenarios plus random traffic
// compared each cycle against a queue-based frame model.
module tb_tdm_demux;

  localparam int unsigned DW  = 8;
  localparam int unsigned NCH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     din;
  logic              din_valid;
  logic              sync;
  logic [NCH*DW-1:0] dout;
  logic              frame_valid;
  logic              sync_err;
  logic              locked;
`ifdef TDM_DEMUX_PARITY_EN
  logic              din_par;
  logic              par_err;
`endif

  always #5 clk = ~clk;

  tdm_demux #(
    .DW  (DW),
    .NCH (NCH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .dout        (dout),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked)
`ifdef TDM_DEMUX_PARITY_EN
    ,
    .din_par     (din_par),
    .par_err     (par_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: samples of the frame being collected, in arrival order.
  logic [DW-1:0]     q [$];
  bit                m_lock = 1'b0;
  bit                m_bad  = 1'b0;
  logic              m_fv, m_se, m_pe;
  logic [NCH*DW-1:0] m_dout = '0;

  int cyc = 0;
  int fv_at [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic v, input logic s,
                       input logic [DW-1:0] d, input logic pe);
    m_fv = 1'b0;
    m_se = 1'b0;
    m_pe = 1'b0;
    if (r) begin
      q.delete();
      m_lock = 1'b0;
      m_bad  = 1'b0;
      m_dout = '0;
    end else if (v) begin
      if (s) begin
        if (m_lock && q.size() != 0) m_se = 1'b1;
        m_lock = 1'b1;
        q.delete();
        q.push_back(d);
        m_bad = pe;
      end else if (m_lock) begin
        if (q.size() == 0) begin
          m_se   = 1'b1;
          m_lock = 1'b0;
          m_bad  = 1'b0;
        end else begin
          q.push_back(d);
          m_bad = m_bad | pe;
          if (q.size() == int'(NCH)) begin
            if (m_bad) begin
              m_pe = 1'b1;
            end else begin
              m_fv = 1'b1;
              for (int k = 0; k < int'(NCH); k++) m_dout[k*DW +: DW] = q[k];
            end
            q.delete();
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s,
                      input logic [DW-1:0] d, input logic pe = 1'b0);
    logic pe_eff;
    @(negedge clk);
    rst       = r;
    din_valid = v;
    sync      = s;
    din       = d;
`ifdef TDM_DEMUX_PARITY_EN
    din_par   = (^d) ^ pe;
    pe_eff    = pe;
`else
    pe_eff    = 1'b0;
`endif
    @(posedge clk);
    model(r, v, s, d, pe_eff);
    cyc++;
    #1;
    if (frame_valid === 1'b1) fv_at.push_back(cyc + 1);
    check("frame_valid", frame_valid, m_fv);
    check("sync_err", sync_err, m_se);
    check("locked", locked, m_lock);
    check("dout", dout, m_dout);
`ifdef TDM_DEMUX_PARITY_EN
    check("par_err", par_err, m_pe);
`endif
  endtask

  initial begin
    int n_fv;
    int c0, c1;
    logic v, s, pe, r;
    logic [DW-1:0] d;

    rst = 1'b1; din_valid = 1'b0; sync = 1'b0; din = '0;
`ifdef TDM_DEMUX_PARITY_EN
    din_par = 1'b0;
`endif

    // Reset state.
    step(1, 0, 0, 8'h00);
    step(1, 1, 1, 8'hFF);
    check("reset_dout", dout, 0);

    // Basic frame.
    step(0, 1, 1, 8'h11);
    step(0, 1, 0, 8'h22);
    step(0, 1, 0, 8'h33);
    step(0, 1, 0, 8'h44);
    check("t1_fv", frame_valid, 1);
    check("t1_dout", dout, 32'h44332211);
    check("t1_locked", locked, 1);

    // Two back-to-back frames at full rate.
    cyc = 0;
    fv_at.delete();
    for (int i = 0; i < 8; i++) step(0, 1, (i % 4) == 0, 8'(8'h60 + i));
    c0 = (fv_at.size() > 0) ? fv_at[0] : -1;
    c1 = (fv_at.size() > 1) ? fv_at[1] : -1;
    check("t2_nfv", fv_at.size(), 2);
    check("t2_cyc0", c0, 5);
    check("t2_cyc1", c1, 9);
    check("t2_dout", dout, 32'h67666564);

    // Early sync drops the partial frame.
    step(0, 1, 1, 8'hA0);
    step(0, 1, 0, 8'hA1);
    step(0, 1, 1, 8'hB0);
    check("t3_serr", sync_err, 1);
    step(0, 1, 0, 8'hB1);
    step(0, 1, 0, 8'hB2);
    step(0, 1, 0, 8'hB3);
    check("t3_dout", dout, 32'hB3B2B1B0);

    // Missing sync at slot 0, hunt, then recovery.
    step(0, 1, 1, 8'hC0);
    step(0, 1, 0, 8'hC1);
    step(0, 1, 0, 8'hC2);
    step(0, 1, 0, 8'hC3);
    step(0, 1, 0, 8'hD0);
    check("t4_serr", sync_err, 1);
    check("t4_unlock", locked, 0);
    step(0, 1, 0, 8'hD1);
    step(0, 1, 0, 8'hD2);
    check("t4_hunt_quiet", sync_err, 0);
    step(0, 1, 1, 8'hE0);
    step(0, 1, 0, 8'hE1);
    step(0, 1, 0, 8'hE2);
    step(0, 1, 0, 8'hE3);
    check("t4_dout", dout, 32'hE3E2E1E0);

    // Gapped valid.
    fv_at.delete();
    step(0, 1, 1, 8'h50);
    step(0, 0, 1, 8'hEE);
    step(0, 1, 0, 8'h51);
    step(0, 0, 0, 8'hEE);
    step(0, 1, 0, 8'h52);
    step(0, 0, 1, 8'hEE);
    step(0, 1, 0, 8'h53);
    step(0, 0, 0, 8'hEE);
    n_fv = fv_at.size();
    check("t5_nfv", n_fv, 1);
    check("t5_dout", dout, 32'h53525150);

`ifdef TDM_DEMUX_PARITY_EN
    // Parity error in slot 2 suppresses the frame.
    step(0, 1, 1, 8'h70);
    step(0, 1, 0, 8'h71);
    step(0, 1, 0, 8'h72, 1'b1);
    step(0, 1, 0, 8'h73);
    check("t6_perr", par_err, 1);
    check("t6_fv", frame_valid, 0);
    check("t6_dout", dout, 32'h53525150);
    step(0, 1, 1, 8'h80);
    step(0, 1, 0, 8'h81);
    step(0, 1, 0, 8'h82);
    step(0, 1, 0, 8'h83);
    check("t6_clean", dout, 32'h83828180);
`endif

    // Reset mid-frame loses the partial frame and clears dout.
    step(0, 1, 1, 8'h90);
    step(0, 1, 0, 8'h91);
    step(1, 1, 0, 8'h92);
    check("rst_dout", dout, 0);
    check("rst_locked", locked, 0);
    step(0, 1, 0, 8'h93);
    step(0, 1, 0, 8'h94);
    check("rst_no_frame", frame_valid, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom % 150) == 0;
      v  = ($urandom % 4) != 0;
      s  = (q.size() == 0) ? (($urandom % 8) != 0) : (($urandom % 12) == 0);
      pe = ($urandom % 12) == 0;
      d  = 8'($urandom);
      step(r, v, s, d, pe);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
